// File: rtl/adc_dual_sequencer.sv
// adc_dual_sequencer
// Steps through NUM_SLOTS channel slots. Each slot sends one command to ADC A
// and one to ADC B, collects both tagged samples, and presents the pair as a
// one-cycle sample_valid strobe. frame_done marks the last slot of a frame.
//
// Optional feature: define ADC_SEQ_TIMEOUT_EN to abandon a slot after
// TIMEOUT_CYCLES. Missing samples then read 12'hFFF and error[1] is set.
//
// Ports:
//   clock_clk, reset_sink_reset      clock, synchronous active-high reset
//   enable, error_clr                run request, sticky-error clear
//   command*/command_2*              command streams to ADC A / ADC B
//   response*/response_2*            sample streams from ADC A / ADC B
//   sample_valid/slot/data_a/data_b  per-slot result
//   frame_done, busy, error          framing strobe, activity, sticky errors
module adc_dual_sequencer #(
    parameter int          NUM_SLOTS      = 4,
    parameter logic [39:0] CH_LIST_A      = 40'h0,
    parameter logic [39:0] CH_LIST_B      = 40'h0,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clock_clk,
    input  logic        reset_sink_reset,
    input  logic        enable,
    input  logic        error_clr,
    output logic        command_valid,
    output logic [4:0]  command_channel,
    output logic        command_startofpacket,
    output logic        command_endofpacket,
    input  logic        command_ready,
    output logic        command_2_valid,
    output logic [4:0]  command_2_channel,
    output logic        command_2_startofpacket,
    output logic        command_2_endofpacket,
    input  logic        command_2_ready,
    input  logic        response_valid,
    input  logic [4:0]  response_channel,
    input  logic [11:0] response_data,
    input  logic        response_startofpacket,
    input  logic        response_endofpacket,
    input  logic        response_2_valid,
    input  logic [4:0]  response_2_channel,
    input  logic [11:0] response_2_data,
    input  logic        response_2_startofpacket,
    input  logic        response_2_endofpacket,
    output logic        sample_valid,
    output logic [2:0]  sample_slot,
    output logic [11:0] sample_data_a,
    output logic [11:0] sample_data_b,
    output logic        frame_done,
    output logic        busy,
    output logic [1:0]  error
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;

    localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);

    // Unpack the channel lists into per-slot lookup tables.
    logic [4:0] ch_tbl_a [8];
    logic [4:0] ch_tbl_b [8];
    for (genvar gi = 0; gi < 8; gi++) begin : g_ch_tbl
        assign ch_tbl_a[gi] = CH_LIST_A[5*gi +: 5];
        assign ch_tbl_b[gi] = CH_LIST_B[5*gi +: 5];
    end

    state_t      state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic        en_q;
    logic        acc_a_q, acc_a_d, acc_b_q, acc_b_d;   // command accepted this slot
    logic        got_a_q, got_a_d, got_b_q, got_b_d;   // response captured this slot
    logic [11:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic [11:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic [2:0]  out_slot_q, out_slot_d;
    logic [1:0]  error_q, error_d;

    logic [4:0]  ch_a, ch_b;
    logic        active, cmd_a_valid, cmd_b_valid, hs_a, hs_b;
    logic        acc_a_now, acc_b_now, cap_a, cap_b, got_a_now, got_b_now, both_got;
    logic        bad_resp, timeout;

    assign ch_a        = ch_tbl_a[slot_q];
    assign ch_b        = ch_tbl_b[slot_q];
    assign active      = (state_q == ISSUE) || (state_q == WAIT);
    assign cmd_a_valid = (state_q == ISSUE) && !acc_a_q;
    assign cmd_b_valid = (state_q == ISSUE) && !acc_b_q;
    assign hs_a        = cmd_a_valid && command_ready;
    assign hs_b        = cmd_b_valid && command_2_ready;
    assign acc_a_now   = acc_a_q || hs_a;
    assign acc_b_now   = acc_b_q || hs_b;
    // A response may land in the same cycle as its command handshake.
    assign cap_a       = response_valid && active && acc_a_now && !got_a_q;
    assign cap_b       = response_2_valid && active && acc_b_now && !got_b_q;
    assign got_a_now   = got_a_q || cap_a;
    assign got_b_now   = got_b_q || cap_b;
    assign both_got    = got_a_now && got_b_now;
    assign bad_resp    = (response_valid && !cap_a) || (cap_a && (response_channel != ch_a)) ||
                         (response_2_valid && !cap_b) || (cap_b && (response_2_channel != ch_b));

`ifdef ADC_SEQ_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    assign cnt_d   = active ? cnt_q + 32'd1 : 32'd0;
    assign timeout = active && (cnt_q == 32'(TIMEOUT_CYCLES - 1)) && !both_got;

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) cnt_q <= '0;
        else                  cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

    logic unused_framing;
    assign unused_framing = response_startofpacket ^ response_endofpacket ^
                            response_2_startofpacket ^ response_2_endofpacket;

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        acc_a_d    = acc_a_now;
        acc_b_d    = acc_b_now;
        got_a_d    = got_a_now;
        got_b_d    = got_b_now;
        hold_a_d   = cap_a ? response_data : hold_a_q;
        hold_b_d   = cap_b ? response_2_data : hold_b_q;
        out_a_d    = out_a_q;
        out_b_d    = out_b_q;
        out_slot_d = out_slot_q;
        error_d    = error_clr ? 2'b00 : error_q;
        error_d[0] = error_d[0] | bad_resp;

        case (state_q)
            IDLE: begin
                slot_d = 3'd0;
                if (en_q) state_d = ISSUE;
            end
            ISSUE: begin
                if (acc_a_now && acc_b_now) state_d = WAIT;
            end
            WAIT: begin
                if (both_got) state_d = STORE;
            end
            STORE: begin
                acc_a_d = 1'b0;
                acc_b_d = 1'b0;
                got_a_d = 1'b0;
                got_b_d = 1'b0;
                slot_d  = (slot_q == LAST_SLOT) ? 3'd0 : slot_q + 3'd1;
                state_d = ((slot_q == LAST_SLOT) && !en_q) ? IDLE : ISSUE;
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            if (!got_a_now) hold_a_d = 12'hFFF;
            if (!got_b_now) hold_b_d = 12'hFFF;
            error_d[1] = 1'b1;
            state_d    = STORE;
        end

        // Result registers load on entry to STORE and hold until the next one.
        if ((state_d == STORE) && (state_q != STORE)) begin
            out_a_d    = hold_a_d;
            out_b_d    = hold_b_d;
            out_slot_d = slot_q;
        end
    end

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            state_q    <= IDLE;
            slot_q     <= 3'd0;
            en_q       <= 1'b0;
            acc_a_q    <= 1'b0;
            acc_b_q    <= 1'b0;
            got_a_q    <= 1'b0;
            got_b_q    <= 1'b0;
            hold_a_q   <= 12'h0;
            hold_b_q   <= 12'h0;
            out_a_q    <= 12'h0;
            out_b_q    <= 12'h0;
            out_slot_q <= 3'd0;
            error_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            en_q       <= enable;
            acc_a_q    <= acc_a_d;
            acc_b_q    <= acc_b_d;
            got_a_q    <= got_a_d;
            got_b_q    <= got_b_d;
            hold_a_q   <= hold_a_d;
            hold_b_q   <= hold_b_d;
            out_a_q    <= out_a_d;
            out_b_q    <= out_b_d;
            out_slot_q <= out_slot_d;
            error_q    <= error_d;
        end
    end

    assign command_valid           = cmd_a_valid;
    assign command_channel         = cmd_a_valid ? ch_a : 5'd0;
    assign command_startofpacket   = cmd_a_valid && (slot_q == 3'd0);
    assign command_endofpacket     = cmd_a_valid && (slot_q == LAST_SLOT);
    assign command_2_valid         = cmd_b_valid;
    assign command_2_channel       = cmd_b_valid ? ch_b : 5'd0;
    assign command_2_startofpacket = cmd_b_valid && (slot_q == 3'd0);
    assign command_2_endofpacket   = cmd_b_valid && (slot_q == LAST_SLOT);
    assign sample_valid            = (state_q == STORE);
    assign sample_slot             = out_slot_q;
    assign sample_data_a           = out_a_q;
    assign sample_data_b           = out_b_q;
    assign frame_done              = (state_q == STORE) && (slot_q == LAST_SLOT);
    assign busy                    = (state_q != IDLE);
    assign error                   = error_q;

endmodule

// File: tb/tb_adc_dual_sequencer.sv
module tb_adc_dual_sequencer;

    typedef struct packed {
        logic [2:0]  slot;
        logic [11:0] a;
        logic [11:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        srst;
    logic        enable, error_clr;
    logic        command_valid, command_startofpacket, command_endofpacket, command_ready;
    logic [4:0]  command_channel;
    logic        command_2_valid, command_2_startofpacket, command_2_endofpacket, command_2_ready;
    logic [4:0]  command_2_channel;
    logic        response_valid, response_2_valid;
    logic [4:0]  response_channel, response_2_channel;
    logic [11:0] response_data, response_2_data;
    logic        sample_valid, frame_done, busy;
    logic [2:0]  sample_slot;
    logic [11:0] sample_data_a, sample_data_b;
    logic [1:0]  error;

    int tests = 0;
    int failed = 0;
    int cycle_cnt = 0;
    int fd_count = 0;
    int sv_times [$];
    exp_t sb_q [$];

    logic [4:0] ch_a_tbl [4] = '{5'd1, 5'd2, 5'd5, 5'd6};
    logic [4:0] ch_b_tbl [4] = '{5'd3, 5'd4, 5'd7, 5'd8};

    logic ovr_a = 1'b0;
    logic inject_a = 1'b0;
    logic hold_b = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    adc_dual_sequencer #(
        .NUM_SLOTS     (4),
        .CH_LIST_A     ({20'h0, 5'd6, 5'd5, 5'd2, 5'd1}),
        .CH_LIST_B     ({20'h0, 5'd8, 5'd7, 5'd4, 5'd3}),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock_clk               (clk),
        .reset_sink_reset        (srst),
        .enable                  (enable),
        .error_clr               (error_clr),
        .command_valid           (command_valid),
        .command_channel         (command_channel),
        .command_startofpacket   (command_startofpacket),
        .command_endofpacket     (command_endofpacket),
        .command_ready           (command_ready),
        .command_2_valid         (command_2_valid),
        .command_2_channel       (command_2_channel),
        .command_2_startofpacket (command_2_startofpacket),
        .command_2_endofpacket   (command_2_endofpacket),
        .command_2_ready         (command_2_ready),
        .response_valid          (response_valid),
        .response_channel        (response_channel),
        .response_data           (response_data),
        .response_startofpacket  (1'b0),
        .response_endofpacket    (1'b0),
        .response_2_valid        (response_2_valid),
        .response_2_channel      (response_2_channel),
        .response_2_data         (response_2_data),
        .response_2_startofpacket(1'b0),
        .response_2_endofpacket  (1'b0),
        .sample_valid            (sample_valid),
        .sample_slot             (sample_slot),
        .sample_data_a           (sample_data_a),
        .sample_data_b           (sample_data_b),
        .frame_done              (frame_done),
        .busy                    (busy),
        .error                   (error)
    );

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    logic       pend_a = 1'b0, pend_b = 1'b0;
    logic [4:0] pend_ch_a, pend_ch_b;
    logic [1:0] pend_slot_a;
    logic [1:0] cmd_slot_a = 2'd0, cmd_slot_b = 2'd0;

    always @(negedge clk) begin
        response_valid   = 1'b0;
        response_2_valid = 1'b0;
        if (pend_a) begin
            response_valid   = 1'b1;
            response_channel = (ovr_a && pend_slot_a == 2'd0) ? 5'd7 : pend_ch_a;
            response_data    = 12'h100 + {7'd0, pend_ch_a};
        end else if (inject_a) begin
            response_valid   = 1'b1;
            response_channel = 5'd1;
            response_data    = 12'hABC;
        end
        if (pend_b && !hold_b) begin
            response_2_valid   = 1'b1;
            response_2_channel = pend_ch_b;
            response_2_data    = 12'h400 + {7'd0, pend_ch_b};
        end
        pend_a = 1'b0;
        pend_b = 1'b0;
        if (srst) begin
            cmd_slot_a = 2'd0;
            cmd_slot_b = 2'd0;
        end else begin
            if (command_valid && command_ready) begin
                check("cmd_a_channel", command_channel, ch_a_tbl[cmd_slot_a]);
                check("cmd_a_sop", command_startofpacket, (cmd_slot_a == 2'd0));
                check("cmd_a_eop", command_endofpacket, (cmd_slot_a == 2'd3));
                $display("[TB] cmd A slot=%0d ch=%0d", cmd_slot_a, command_channel);
                pend_a      = 1'b1;
                pend_ch_a   = command_channel;
                pend_slot_a = cmd_slot_a;
                cmd_slot_a  = cmd_slot_a + 2'd1;
            end
            if (command_2_valid && command_2_ready) begin
                check("cmd_b_channel", command_2_channel, ch_b_tbl[cmd_slot_b]);
                check("cmd_b_sop", command_2_startofpacket, (cmd_slot_b == 2'd0));
                check("cmd_b_eop", command_2_endofpacket, (cmd_slot_b == 2'd3));
                $display("[TB] cmd B slot=%0d ch=%0d", cmd_slot_b, command_2_channel);
                pend_b     = 1'b1;
                pend_ch_b  = command_2_channel;
                cmd_slot_b = cmd_slot_b + 2'd1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!srst && sample_valid) begin
            sv_times.push_back(cycle_cnt);
            if (frame_done) fd_count++;
            $display("[TB] sample slot=%0d a=%03h b=%03h frame_done=%0b",
                     sample_slot, sample_data_a, sample_data_b, frame_done);
            check("sb_nonempty", (sb_q.size() > 0), 1'b1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sample_slot", sample_slot, e.slot);
                check("sample_data_a", sample_data_a, e.a);
                check("sample_data_b", sample_data_b, e.b);
                check("frame_done", frame_done, (e.slot == 3'd3));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int s = 0; s < 4; s++) begin
            sb_q.push_back('{slot: 3'(s), a: 12'h100 + {7'd0, ch_a_tbl[s]},
                             b: 12'h400 + {7'd0, ch_b_tbl[s]}});
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_idle", busy, 1'b0);
    endtask

    task automatic start_frame();
        enable = 1'b1;
        tick();
        tick();
        enable = 1'b0;
    endtask

    initial begin
        int base, fd0, t0, n;
        srst = 1'b1; enable = 1'b0; error_clr = 1'b0;
        command_ready = 1'b1; command_2_ready = 1'b1;
        repeat (3) tick();
        check("rst_cmd_valid", command_valid, 1'b0);
        check("rst_cmd2_valid", command_2_valid, 1'b0);
        check("rst_sample_valid", sample_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_error", error, 2'b00);
        check("rst_data_a", sample_data_a, 12'h000);
        srst = 1'b0;
        tick();

        push_frame();
        base = sv_times.size();
        fd0  = fd_count;
        enable = 1'b1;
        tick();
        check("en_latency_idle", command_valid, 1'b0);
        tick();
        check("en_latency_issue", command_valid, 1'b1);
        check("first_cmd_a_ch", command_channel, 5'd1);
        check("first_cmd_b_ch", command_2_channel, 5'd3);
        check("first_busy", busy, 1'b1);
        enable = 1'b0;
        wait_idle(40);
        check("frame_samples", sv_times.size() - base, 4);
        if (sv_times.size() - base == 4) begin
            for (int i = 1; i < 4; i++)
                check("slot_period", sv_times[base+i] - sv_times[base+i-1], 3);
        end
        check("frame_done_count", fd_count - fd0, 1);
        check("sb_drained_1", sb_q.size(), 0);
        check("error_clean", error, 2'b00);

        push_frame();
        command_ready = 1'b0;
        start_frame();
        check("bp_a_valid_0", command_valid, 1'b1);
        check("bp_b_valid_0", command_2_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_a_valid", command_valid, 1'b1);
            check("bp_b_dropped", command_2_valid, 1'b0);
            check("bp_no_store", sample_valid, 1'b0);
        end
        command_ready = 1'b1;
        wait_idle(60);
        check("sb_drained_2", sb_q.size(), 0);

        push_frame();
        ovr_a = 1'b1;
        start_frame();
        wait_idle(40);
        ovr_a = 1'b0;
        check("mismatch_error", error, 2'b01);
        check("sb_drained_3", sb_q.size(), 0);
        error_clr = 1'b1;
        tick();
        error_clr = 1'b0;
        check("error_cleared", error, 2'b00);

        inject_a  = 1'b1;
        error_clr = 1'b1;
        tick();
        inject_a  = 1'b0;
        error_clr = 1'b0;
        check("idle_resp_error", error, 2'b01);
        check("idle_resp_no_sample", sample_valid, 1'b0);
        check("idle_resp_busy", busy, 1'b0);
        tick();
        check("idle_resp_no_sample2", sample_valid, 1'b0);
        error_clr = 1'b1;
        tick();
        error_clr = 1'b0;
        check("error_cleared_2", error, 2'b00);

`ifdef ADC_SEQ_TIMEOUT_EN
        sb_q.push_back('{slot: 3'd0, a: 12'h101, b: 12'hFFF});
        hold_b = 1'b1;
        enable = 1'b1;
        tick();
        tick();
        t0 = cycle_cnt;
        n  = 0;
        while (!sample_valid && n < 40) begin
            tick();
            n++;
        end
        check("timeout_store", sample_valid, 1'b1);
        check("timeout_latency", cycle_cnt - t0, 16);
        check("timeout_data_b", sample_data_b, 12'hFFF);
        check("timeout_error", error, 2'b10);
        enable = 1'b0;
        repeat (3) tick();
        check("mid_wait_busy", busy, 1'b1);
        srst = 1'b1;
        tick();
        check("rst2_cmd_valid", command_valid, 1'b0);
        check("rst2_sample_valid", sample_valid, 1'b0);
        check("rst2_busy", busy, 1'b0);
        check("rst2_error", error, 2'b00);
        check("rst2_data_b", sample_data_b, 12'h000);
        check("rst2_frame_done", frame_done, 1'b0);
        srst   = 1'b0;
        hold_b = 1'b0;
        tick();
`else
        t0 = 0;
        n  = 0;
`endif

        check("sb_final", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
